// File: rtl/sdram_word_responder.sv
// Responder for the CPU SDRAM word interface: each 32-bit command becomes two
// 16-bit backend transactions (low half, then high half), guarded by a watchdog.
module sdram_word_responder #(
   parameter int ADDR_W  = 24,
   parameter int TIMEOUT = 1024,
   parameter int TMO_W   = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              word_rd,
   input  logic              word_wr,
   input  logic [ADDR_W-1:0] word_addr,
   input  logic [31:0]       word_wdata,
   output logic [31:0]       word_rdata,
   output logic              word_busy,
   output logic              word_rdata_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W:0]   mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata,
   input  logic              err_clr,
   output logic              protocol_err,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LO_REQ  = 3'd1,
      ST_LO_WAIT = 3'd2,
      ST_HI_REQ  = 3'd3,
      ST_HI_WAIT = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   function automatic logic is_req(input state_e s);
      return (s == ST_LO_REQ) || (s == ST_HI_REQ);
   endfunction

   function automatic logic is_hi(input state_e s);
      return (s == ST_HI_REQ) || (s == ST_HI_WAIT);
   endfunction

   function automatic logic is_active(input state_e s);
      return (s == ST_LO_REQ) || (s == ST_LO_WAIT) || (s == ST_HI_REQ) || (s == ST_HI_WAIT);
   endfunction

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [15:0]         rlo_q, rlo_d;
   logic [TMO_W-1:0]    wdog_q, wdog_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                busy_q, busy_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W:0]     mem_addr_q, mem_addr_d;
   logic [15:0]         mem_wdata_q, mem_wdata_d;
   logic                prot_err_q, prot_err_d;
   logic                tmo_err_q, tmo_err_d;

   logic                cmd_s;
   logic                ack_s;
   logic                wdog_exp_s;
   logic                tmo_set_s;
   logic                prot_set_s;

   assign cmd_s      = word_rd | word_wr;
   // An ack only counts while our request is actually up; stray acks are dropped.
   assign ack_s      = mem_req_q & mem_ack;
   assign wdog_exp_s = (wdog_q == TMO_LAST);

   // Next-state logic: command capture, half sequencing, read assembly, watchdog abort.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      rlo_d     = rlo_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      tmo_set_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_s) begin
               addr_d  = word_addr;
               wdata_d = word_wdata;
               we_d    = word_wr;
               state_d = ST_LO_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LO_REQ: begin
            if (ack_s && we_q) begin
               state_d = ST_HI_REQ;
            end else if (ack_s && mem_rvalid) begin
               rlo_d   = mem_rdata;
               state_d = ST_HI_REQ;
            end else if (ack_s) begin
               state_d = ST_LO_WAIT;
            end else if (wdog_exp_s) begin
               state_d   = ST_DONE;
               tmo_set_s = 1'b1;
               rvalid_d  = ~we_q;
               rdata_d   = we_q ? rdata_q : 32'hFFFF_FFFF;
            end else begin
               state_d = ST_LO_REQ;
            end
         end
         ST_LO_WAIT: begin
            if (mem_rvalid) begin
               rlo_d   = mem_rdata;
               state_d = ST_HI_REQ;
            end else if (wdog_exp_s) begin
               state_d   = ST_DONE;
               tmo_set_s = 1'b1;
               rvalid_d  = ~we_q;
               rdata_d   = we_q ? rdata_q : 32'hFFFF_FFFF;
            end else begin
               state_d = ST_LO_WAIT;
            end
         end
         ST_HI_REQ: begin
            if (ack_s && we_q) begin
               state_d = ST_DONE;
            end else if (ack_s && mem_rvalid) begin
               rdata_d  = {mem_rdata, rlo_q};
               rvalid_d = 1'b1;
               state_d  = ST_DONE;
            end else if (ack_s) begin
               state_d = ST_HI_WAIT;
            end else if (wdog_exp_s) begin
               state_d   = ST_DONE;
               tmo_set_s = 1'b1;
               rvalid_d  = ~we_q;
               rdata_d   = we_q ? rdata_q : 32'hFFFF_FFFF;
            end else begin
               state_d = ST_HI_REQ;
            end
         end
         ST_HI_WAIT: begin
            if (mem_rvalid) begin
               rdata_d  = {mem_rdata, rlo_q};
               rvalid_d = 1'b1;
               state_d  = ST_DONE;
            end else if (wdog_exp_s) begin
               state_d   = ST_DONE;
               tmo_set_s = 1'b1;
               rvalid_d  = ~we_q;
               rdata_d   = we_q ? rdata_q : 32'hFFFF_FFFF;
            end else begin
               state_d = ST_HI_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered-output next values, watchdog and sticky error flags.
   always_comb begin
      busy_d      = is_active(state_d);
      // Request comes up one cycle after entering a REQ state, which also leaves
      // a dead cycle between the low ack and the high request.
      mem_req_d   = is_req(state_q) && (state_d == state_q);
      mem_we_d    = is_active(state_d) ? we_d : 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (is_hi(state_d)) begin
         mem_addr_d  = {addr_d, 1'b1};
         mem_wdata_d = wdata_d[31:16];
      end else if (is_active(state_d)) begin
         mem_addr_d  = {addr_d, 1'b0};
         mem_wdata_d = wdata_d[15:0];
      end else begin
         mem_addr_d  = mem_addr_q;
         mem_wdata_d = mem_wdata_q;
      end
      if (state_d != state_q) begin
         wdog_d = {TMO_W{1'b0}};
      end else if (is_active(state_q)) begin
         wdog_d = wdog_q + TMO_W'(1);
      end else begin
         wdog_d = {TMO_W{1'b0}};
      end
      prot_set_s = (word_rd & word_wr) | (cmd_s & (state_q != ST_IDLE));
      if (prot_set_s) begin
         prot_err_d = 1'b1;
      end else if (err_clr) begin
         prot_err_d = 1'b0;
      end else begin
         prot_err_d = prot_err_q;
      end
      if (tmo_set_s) begin
         tmo_err_d = 1'b1;
      end else if (err_clr) begin
         tmo_err_d = 1'b0;
      end else begin
         tmo_err_d = tmo_err_q;
      end
   end

   // State and output registers; reset abandons any command in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= 32'h0000_0000;
         we_q        <= 1'b0;
         rlo_q       <= 16'h0000;
         wdog_q      <= {TMO_W{1'b0}};
         rdata_q     <= 32'h0000_0000;
         rvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {(ADDR_W+1){1'b0}};
         mem_wdata_q <= 16'h0000;
         prot_err_q  <= 1'b0;
         tmo_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         rlo_q       <= rlo_d;
         wdog_q      <= wdog_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         busy_q      <= busy_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         prot_err_q  <= prot_err_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   assign word_rdata       = rdata_q;
   assign word_busy        = busy_q;
   assign word_rdata_valid = rvalid_q;
   assign mem_req          = mem_req_q;
   assign mem_we           = mem_we_q;
   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign protocol_err     = prot_err_q;
   assign timeout_err      = tmo_err_q;

endmodule
